// File: rtl/muldiv_if.sv
// Decoder <-> multiply/divide sequencer handshake.
// The decoder side (master) issues one operation with start and may squash it
// with flush; the sequencer side (slave) holds the pipeline with stall and
// returns a registered result qualified by a one-cycle done pulse.
interface muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start, funct3, a, b, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, funct3, a, b, flush,
        output stall, done, result
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV32M multi-cycle multiply/divide sequencer.
// Every op runs for exactly WIDTH iterations on operand magnitudes (radix-2
// shift-add multiply or restoring divide), then one fix-up cycle applies the
// sign correction and selects the result half. Fixed latency keeps the CPU
// hazard logic trivial: done always arrives WIDTH+2 cycles after start.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic               r_neg_mul;
    logic               r_neg_quo;
    logic               r_neg_rem;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush && !rst;

    // Operand signs only matter for the signed flavours: MULH/DIV/REM treat both
    // operands as signed, MULHSU only rs1. MUL's low half is sign-agnostic.
    assign w_sa = bus.a[WIDTH-1] && ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                                     (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110));
    assign w_sb = bus.b[WIDTH-1] && ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                                     (bus.funct3 == 3'b110));

    // Multiply step: acc = {partial product, remaining multiplier bits}.
    // The carry out of the add becomes the new top bit after the right shift.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                        {1'b0, (r_acc[0] ? r_opb : {WIDTH{1'b0}})};
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: acc = {remainder, dividend/quotient}. A zero divisor always
    // "succeeds", giving an all-ones quotient and remainder = dividend for free.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_opb};
    assign w_div_step  = w_div_diff[WIDTH]
                       ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                       : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = neg2_if(r_acc, r_neg_mul);
    assign w_quo  = neg_if(r_acc[WIDTH-1:0], r_neg_quo);
    assign w_rem  = neg_if(r_acc[2*WIDTH-1:WIDTH], r_neg_rem);

    // Result selection during the fix-up cycle.
    always_comb begin
        w_fix = w_prod[WIDTH-1:0];
        case (r_op)
            3'b000:                 w_fix = w_prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_fix = w_quo;
            default:                w_fix = w_rem;
        endcase
    end

    // Next-state logic; flush squashes RUN/FIX but never a DONE already reached.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start && !bus.flush) w_next = S_RUN;
            S_RUN:   if (bus.flush) w_next = S_IDLE;
                     else if (r_cnt == CNT_W'(1)) w_next = S_FIX;
            S_FIX:   w_next = bus.flush ? S_IDLE : S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Control state: FSM, iteration counter and the architecturally visible result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_cnt <= CNT_W'(WIDTH);
            else if (r_state == S_RUN)
                r_cnt <= r_cnt - CNT_W'(1);
            if (r_state == S_FIX && !bus.flush)
                r_result <= w_fix;
        end
    end

    // Datapath: capture magnitudes and sign-fix flags on accept, iterate in RUN.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op      <= bus.funct3;
            r_acc     <= {{WIDTH{1'b0}}, neg_if(bus.a, w_sa)};
            r_opb     <= neg_if(bus.b, w_sb);
            r_neg_mul <= w_sa ^ w_sb;
            r_neg_quo <= (w_sa ^ w_sb) && (bus.b != '0);
            r_neg_rem <= w_sa;
        end else if (r_state == S_RUN) begin
            r_acc <= r_op[2] ? w_div_step : w_mul_step;
        end
    end

    assign bus.stall  = w_accept || (r_state == S_RUN) || (r_state == S_FIX);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: a table of single operations with hand-derived results,
// each checked for value, latency and stall profile through a result queue,
// followed by hand-written sequences for ignored start, flush and reset.
module tb_muldiv_ctrl;
    localparam int WIDTH = 32;
    localparam int NV    = 21;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] sb_q[$];
    vec_t tbl[NV];

    muldiv_if #(.WIDTH(WIDTH)) bus ();

    muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_line(input string name, input int act, input int req);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic pop_compare(input string name);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            fail_line({name, "_queue_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check(name, bus.result, e);
        end
    endtask

    // One complete operation: start in cycle 0, done required in cycle 34,
    // stall high through cycle 33, single-cycle done, result held afterwards.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] ve);
        int cyc;
        bit got;
        bit stall_ok;
        @(negedge clk);
        bus.funct3 = f3;
        bus.a      = va;
        bus.b      = vb;
        bus.start  = 1'b1;
        sb_q.push_back(ve);
        #1 check("stall_cycle0", bus.stall, 1);
        cyc = 0;
        got = 0;
        stall_ok = 1;
        while (!got && cyc < 60) begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
            #1;
            if (bus.done) begin
                got = 1;
                check("done_cycle", cyc, 34);
                check("stall_in_done", bus.stall, 0);
                pop_compare("result");
            end else if (bus.stall !== (cyc <= 33)) begin
                stall_ok = 0;
            end
        end
        if (!got) begin
            fail_line("done_timeout", cyc, 34);
            sb_q.delete();
        end
        check("stall_profile", stall_ok, 1);
        @(negedge clk);
        #1;
        check("done_single_pulse", bus.done, 0);
        check("result_hold", bus.result, ve);
    endtask

    initial begin
        int ndone;
        bit quiet;

        tbl[0]  = '{F_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
        tbl[1]  = '{F_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        tbl[2]  = '{F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[3]  = '{F_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        tbl[4]  = '{F_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD};
        tbl[5]  = '{F_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF};
        tbl[6]  = '{F_DIVU,   32'd100,      32'd7,        32'd14};
        tbl[7]  = '{F_REMU,   32'd100,      32'd7,        32'd2};
        tbl[8]  = '{F_DIV,    32'd5,        32'd0,        32'hFFFFFFFF};
        tbl[9]  = '{F_REM,    32'd5,        32'd0,        32'd5};
        tbl[10] = '{F_DIVU,   32'd0,        32'd0,        32'hFFFFFFFF};
        tbl[11] = '{F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        tbl[12] = '{F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        tbl[13] = '{F_DIV,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF};
        tbl[14] = '{F_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9};
        tbl[15] = '{F_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        tbl[16] = '{F_MULHSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001};
        tbl[17] = '{F_MULH,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
        tbl[18] = '{F_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
        tbl[19] = '{F_REM,    32'd7,        32'hFFFFFFFE, 32'd1};
        tbl[20] = '{F_REMU,   32'd7,        32'd0,        32'd7};

        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.a      = '0;
        bus.b      = '0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("reset_stall", bus.stall, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++)
            do_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp);

        // start during RUN is ignored: one done, first op's result
        @(negedge clk);
        bus.funct3 = F_DIVU; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
        sb_q.push_back(32'd14);
        ndone = 0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (cyc == 5) begin
                bus.funct3 = F_MUL; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
            end
            #1;
            if (bus.done) begin
                ndone++;
                if (cyc == 34) pop_compare("ignored_start_result");
                else fail_line("ignored_start_done_cycle", cyc, 34);
            end
        end
        check("ignored_start_done_count", ndone, 1);
        sb_q.delete();

        // flush at cycle 10, restart at cycle 11, done at 45
        @(negedge clk);
        bus.funct3 = F_MUL; bus.a = 32'd7; bus.b = 32'hFFFFFFFD; bus.start = 1'b1;
        ndone = 0;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = (cyc == 10);
            if (cyc == 11) begin
                #1;
                check("flush_stall_low", bus.stall, 0);
                check("flush_result_kept", bus.result, 32'd14);
                bus.funct3 = F_MULHU; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
                bus.start = 1'b1;
                sb_q.push_back(32'hFFFFFFFE);
            end
            #1;
            if (bus.done) begin
                ndone++;
                if (cyc == 45) pop_compare("restart_result");
                else fail_line("restart_done_cycle", cyc, 45);
            end
        end
        check("flush_done_count", ndone, 1);
        sb_q.delete();

        // flush together with start in IDLE: start dropped
        @(negedge clk);
        bus.funct3 = F_MUL; bus.a = 32'd3; bus.b = 32'd3;
        bus.start = 1'b1; bus.flush = 1'b1;
        #1 check("flush_idle_stall", bus.stall, 0);
        quiet = 1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.flush = 1'b0;
            #1;
            if (bus.done || bus.stall) quiet = 0;
        end
        check("flush_idle_no_activity", quiet, 1);

        // flush during DONE has no effect
        @(negedge clk);
        bus.funct3 = F_REMU; bus.a = 32'd50; bus.b = 32'd7; bus.start = 1'b1;
        sb_q.push_back(32'd1);
        ndone = 0;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = (cyc == 34);
            #1;
            if (bus.done) begin
                ndone++;
                if (cyc == 34) pop_compare("flush_in_done_result");
                else fail_line("flush_in_done_cycle", cyc, 34);
            end
        end
        bus.flush = 1'b0;
        check("flush_in_done_count", ndone, 1);
        sb_q.delete();

        // reset mid-operation at cycle 20
        @(negedge clk);
        bus.funct3 = F_MUL; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1;
        ndone = 0;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rst = (cyc == 20);
            #1;
            if (bus.done) ndone++;
        end
        check("rst_stall", bus.stall, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        check("rst_no_done", ndone, 0);
        do_op(F_MUL, 32'd3, 32'd4, 32'd12);

        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
